// File: rtl/acc_bank_pkg.sv
// acc_bank_pkg: shared types, defaults and next-value calculation for acc_bank.
// Optional feature macro: ACC_BANK_SAT_EN (saturate at the limit instead of wrapping).
package acc_bank_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_NUM_ACC = 4;
  // Widest accumulator the shared step calculation supports.
  localparam int unsigned MAX_W       = 64;

  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_DATA = 2'd1,
    SRC_ALU  = 2'd2
  } src_e;

  typedef struct packed {
    logic [MAX_W-1:0] val;
    logic             wrap;
  } step_res_t;

  localparam logic [MAX_W:0] ONE_EXT = {{MAX_W{1'b0}}, 1'b1};

  // sum is the (w+1)-bit base+step, zero-extended; lim is the w-bit limit, zero-extended.
  function automatic step_res_t step_next(input logic [MAX_W:0]   sum,
                                          input logic [MAX_W-1:0] lim,
                                          input int unsigned      w);
    step_res_t      r;
    logic [MAX_W:0] ones;
    logic           carry;
    ones   = (ONE_EXT << w) - ONE_EXT;
    carry  = |(sum >> w);
    r.val  = '0;
    r.wrap = 1'b0;
    if (lim == '0) begin
      r.wrap = carry;
`ifdef ACC_BANK_SAT_EN
      r.val  = carry ? ones[MAX_W-1:0] : (sum[MAX_W-1:0] & ones[MAX_W-1:0]);
`else
      r.val  = sum[MAX_W-1:0] & ones[MAX_W-1:0];
`endif
    end else if (sum >= {1'b0, lim}) begin
      r.wrap = 1'b1;
`ifdef ACC_BANK_SAT_EN
      r.val  = lim - ONE_EXT[MAX_W-1:0];
`else
      r.val  = '0;
`endif
    end else begin
      r.val  = sum[MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_bank_if.sv
// acc_bank_if: control/data bus of the accumulator bank (clock and reset stay outside).
interface acc_bank_if
  import acc_bank_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_ACC = DEF_NUM_ACC,
  parameter int unsigned SEL_W   = $clog2(NUM_ACC)
);
  logic [SEL_W-1:0]         sel;
  logic [WIDTH-1:0]         dataIn;
  logic [WIDTH-1:0]         aluIn;
  logic                     write_en;
  logic                     alu_en;
  logic                     inc_en;
  logic [WIDTH-1:0]         step;
  logic                     lim_we;
  logic [SEL_W-1:0]         lim_sel;
  logic [SEL_W-1:0]         rd_sel;
  logic [WIDTH-1:0]         dataOut;
  logic [NUM_ACC*WIDTH-1:0] acc_flat;
  logic                     wrap;
  logic                     conflict;
  logic [NUM_ACC-1:0]       zero;

  modport master (
    output sel, dataIn, aluIn, write_en, alu_en, inc_en, step, lim_we, lim_sel, rd_sel,
    input  dataOut, acc_flat, wrap, conflict, zero
  );

  modport slave (
    input  sel, dataIn, aluIn, write_en, alu_en, inc_en, step, lim_we, lim_sel, rd_sel,
    output dataOut, acc_flat, wrap, conflict, zero
  );
endinterface

// File: rtl/acc_cell.sv
// acc_cell: one accumulator channel with its wrap limit register.
module acc_cell
  import acc_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  src_e             src,
  input  logic             inc,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] alu_in,
  input  logic [WIDTH-1:0] step,
  input  logic             lim_we,
  output logic [WIDTH-1:0] value,
  output logic             wrap_req
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] base;
  logic [WIDTH:0]   sum;
  logic [MAX_W:0]   sum_ext;
  logic [MAX_W-1:0] lim_ext;
  step_res_t        res;
  logic             unused_res_hi;

  // Pick the base value, add the stride and resolve the limit check.
  always_comb begin
    case (src)
      SRC_DATA: base = data_in;
      SRC_ALU:  base = alu_in;
      default:  base = acc_q;
    endcase
    sum              = {1'b0, base} + {1'b0, step};
    sum_ext          = '0;
    sum_ext[WIDTH:0] = sum;
    lim_ext          = '0;
    lim_ext[WIDTH-1:0] = lim_q;
    res              = step_next(sum_ext, lim_ext, WIDTH);

    acc_d    = acc_q;
    wrap_req = 1'b0;
    if (en) begin
      if (inc) begin
        acc_d    = res.val[WIDTH-1:0];
        wrap_req = res.wrap;
      end else begin
        acc_d    = base;
      end
    end
    lim_d = lim_we ? data_in : lim_q;
  end

  assign unused_res_hi = ^res.val[MAX_W-1:WIDTH];

  // Accumulator and limit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      lim_q <= '0;
    end else begin
      acc_q <= acc_d;
      lim_q <= lim_d;
    end
  end

  assign value = acc_q;

endmodule

// File: rtl/acc_bank.sv
// acc_bank: bank of NUM_ACC accumulator/counter channels with per-channel wrap limits.
// Optional feature macro: ACC_BANK_SAT_EN (saturating limits, handled in acc_bank_pkg).
module acc_bank
  import acc_bank_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_ACC = DEF_NUM_ACC,
  parameter int unsigned SEL_W   = $clog2(NUM_ACC)
) (
  input  logic     clk,
  input  logic     rst,
  acc_bank_if.slave bus
);

  logic [NUM_ACC-1:0]       ch_en;
  logic [NUM_ACC-1:0]       ch_lim_we;
  logic [NUM_ACC-1:0]       wrap_req;
  logic [WIDTH-1:0]         acc_val [NUM_ACC];
  src_e                     src;
  logic                     load_clash;
  logic                     wrap_q, wrap_d;
  logic                     conflict_q, conflict_d;
  logic [WIDTH-1:0]         rd_mux;
  logic [NUM_ACC*WIDTH-1:0] flat;
  logic [NUM_ACC-1:0]       zero_v;

  // Decode the source and the one-hot channel / limit write enables.
  always_comb begin
    load_clash = bus.write_en & bus.alu_en;
    src        = SRC_HOLD;
    if (bus.write_en && !bus.alu_en) begin
      src = SRC_DATA;
    end else if (bus.alu_en && !bus.write_en) begin
      src = SRC_ALU;
    end
    ch_en     = '0;
    ch_lim_we = '0;
    for (int unsigned i = 0; i < NUM_ACC; i++) begin
      if (bus.sel == SEL_W'(i) && !load_clash) ch_en[i] = 1'b1;
      if (bus.lim_we && bus.lim_sel == SEL_W'(i)) ch_lim_we[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_ACC; g++) begin : g_cell
    acc_cell #(.WIDTH(WIDTH)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (ch_en[g]),
      .src      (src),
      .inc      (bus.inc_en),
      .data_in  (bus.dataIn),
      .alu_in   (bus.aluIn),
      .step     (bus.step),
      .lim_we   (ch_lim_we[g]),
      .value    (acc_val[g]),
      .wrap_req (wrap_req[g])
    );
  end

  // Read mux, flattened view and zero flags, straight from the registers.
  always_comb begin
    rd_mux = '0;
    flat   = '0;
    zero_v = '0;
    for (int unsigned i = 0; i < NUM_ACC; i++) begin
      flat[i*WIDTH +: WIDTH] = acc_val[i];
      zero_v[i]              = (acc_val[i] == '0);
      if (bus.rd_sel == SEL_W'(i)) rd_mux = acc_val[i];
    end
  end

  // Next values of the event pulses.
  always_comb begin
    wrap_d     = |wrap_req;
    conflict_d = load_clash;
  end

  // Event pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.dataOut  = rd_mux;
  assign bus.acc_flat = flat;
  assign bus.zero     = zero_v;
  assign bus.wrap     = wrap_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: directed vector table plus randomized traffic against a behavioural model.
module tb_acc_bank;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;
`ifdef ACC_BANK_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst;

  acc_bank_if #(.WIDTH(W), .NUM_ACC(N), .SEL_W(SW)) bus ();

  acc_bank #(.WIDTH(W), .NUM_ACC(N), .SEL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  int unsigned ref_acc [N];
  int unsigned ref_lim [N];
  bit          ref_wrap;
  bit          ref_conf;

  typedef struct {
    logic [1:0]  sel;
    logic        we, ae, inc, lwe;
    logic [1:0]  lsel;
    logic [15:0] din, alu, step, exp_acc;
    logic        exp_wrap, exp_conf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic [1:0] sel, input logic we, input logic ae,
                              input logic inc, input logic [15:0] din, input logic [15:0] alu,
                              input logic [15:0] step, input logic lwe, input logic [1:0] lsel,
                              input logic [15:0] exp_acc, input logic exp_wrap,
                              input logic exp_conf);
    vec_t v;
    v.sel = sel; v.we = we; v.ae = ae; v.inc = inc; v.din = din; v.alu = alu;
    v.step = step; v.lwe = lwe; v.lsel = lsel; v.exp_acc = exp_acc;
    v.exp_wrap = exp_wrap; v.exp_conf = exp_conf;
    vecs.push_back(v);
  endfunction

  task automatic drive_idle();
    bus.sel = '0; bus.dataIn = '0; bus.aluIn = '0; bus.write_en = 1'b0;
    bus.alu_en = 1'b0; bus.inc_en = 1'b0; bus.step = '0; bus.lim_we = 1'b0;
    bus.lim_sel = '0; bus.rd_sel = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ref_acc[i] = 0;
      ref_lim[i] = 0;
    end
    ref_wrap = 1'b0;
    ref_conf = 1'b0;
  endtask

  // One clock edge worth of the specification rules, on the inputs currently driven.
  task automatic model_update();
    int unsigned b, s, lim, nv;
    int unsigned s_idx;
    s_idx    = int'(bus.sel);
    ref_wrap = 1'b0;
    ref_conf = 1'b0;
    if (bus.write_en && bus.alu_en) begin
      ref_conf = 1'b1;
    end else begin
      if (bus.write_en)    b = int'(bus.dataIn);
      else if (bus.alu_en) b = int'(bus.aluIn);
      else                 b = ref_acc[s_idx];
      nv = b;
      if (bus.inc_en) begin
        s   = b + int'(bus.step);
        lim = ref_lim[s_idx];
        if (lim == 0) begin
          if (s >= (1 << W)) begin
            ref_wrap = 1'b1;
            nv = SAT ? (1 << W) - 1 : s - (1 << W);
          end else begin
            nv = s;
          end
        end else if (s >= lim) begin
          ref_wrap = 1'b1;
          nv = SAT ? lim - 1 : 0;
        end else begin
          nv = s;
        end
      end
      ref_acc[s_idx] = nv;
    end
    if (bus.lim_we) ref_lim[int'(bus.lim_sel)] = int'(bus.dataIn);
  endtask

  task automatic model_check(input string tag);
    logic [63:0] exp_flat;
    logic [3:0]  exp_zero;
    exp_flat = '0;
    exp_zero = '0;
    for (int i = 0; i < N; i++) begin
      exp_flat[i*W +: W] = ref_acc[i][W-1:0];
      exp_zero[i]        = (ref_acc[i] == 0);
    end
    chk({tag, "_dataOut"},  {48'd0, bus.dataOut}, {48'd0, ref_acc[int'(bus.rd_sel)][W-1:0]});
    chk({tag, "_acc_flat"}, bus.acc_flat, exp_flat);
    chk({tag, "_zero"},     {60'd0, bus.zero}, {60'd0, exp_zero});
    chk({tag, "_wrap"},     {63'd0, bus.wrap}, {63'd0, ref_wrap});
    chk({tag, "_conflict"}, {63'd0, bus.conflict}, {63'd0, ref_conf});
  endtask

  // Advance one cycle: model follows the edge, outputs checked on the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check(tag);
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    model_reset();

    // Reset state on every channel.
    for (int i = 0; i < N; i++) begin
      bus.rd_sel = 2'(i);
      #1;
      chk("rst_dataOut", {48'd0, bus.dataOut}, 64'd0);
    end
    chk("rst_zero",     {60'd0, bus.zero}, 64'hF);
    chk("rst_wrap",     {63'd0, bus.wrap}, 64'd0);
    chk("rst_conflict", {63'd0, bus.conflict}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // sel, we, ae, inc, din, alu, step, lwe, lsel, exp_acc, exp_wrap, exp_conf
    add(1, 1, 0, 0, 16'h0010, 0, 0, 0, 0, 16'h0010, 0, 0);
    add(1, 0, 0, 1, 0, 0, 2, 0, 0, 16'h0012, 0, 0);
    add(1, 0, 0, 1, 0, 0, 2, 0, 0, 16'h0014, 0, 0);
    add(1, 0, 0, 1, 0, 0, 2, 0, 0, 16'h0016, 0, 0);
    add(2, 0, 0, 0, 5, 0, 0, 1, 2, 0, 0, 0);
    add(2, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    add(2, 0, 0, 1, 0, 0, 1, 0, 0, 2, 0, 0);
    add(2, 0, 0, 1, 0, 0, 1, 0, 0, 3, 0, 0);
    add(2, 0, 0, 1, 0, 0, 1, 0, 0, 4, 0, 0);
    add(2, 0, 0, 1, 0, 0, 1, 0, 0, SAT ? 16'd4 : 16'd0, 1, 0);
    add(2, 0, 0, 1, 0, 0, 1, 0, 0, SAT ? 16'd4 : 16'd1, SAT, 0);
    add(0, 0, 1, 1, 0, 16'hFFFF, 1, 0, 0, SAT ? 16'hFFFF : 16'h0000, 1, 0);
    add(3, 1, 0, 0, 7, 0, 0, 0, 0, 7, 0, 0);
    add(3, 1, 1, 1, 16'h0099, 16'h0055, 1, 0, 0, 7, 0, 1);
    add(3, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    add(1, 1, 0, 0, 2, 0, 0, 0, 0, 2, 0, 0);
    add(1, 0, 0, 1, 3, 0, 1, 1, 1, 3, 0, 0);
    add(1, 0, 0, 1, 0, 0, 1, 0, 0, SAT ? 16'd2 : 16'd0, 1, 0);
    add(2, 1, 0, 0, 9, 0, 0, 0, 0, 9, 0, 0);
    add(2, 0, 0, 1, 0, 0, 0, 0, 0, SAT ? 16'd4 : 16'd0, 1, 0);
    add(0, 1, 0, 0, 4, 0, 0, 1, 0, 4, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, SAT ? 16'd3 : 16'd0, 1, 0);

    foreach (vecs[k]) begin
      bus.sel = vecs[k].sel;       bus.write_en = vecs[k].we;  bus.alu_en = vecs[k].ae;
      bus.inc_en = vecs[k].inc;    bus.dataIn = vecs[k].din;   bus.aluIn = vecs[k].alu;
      bus.step = vecs[k].step;     bus.lim_we = vecs[k].lwe;   bus.lim_sel = vecs[k].lsel;
      bus.rd_sel = vecs[k].sel;
      tick("vec_model");
      chk($sformatf("vec%0d_acc", k), {48'd0, bus.dataOut}, {48'd0, vecs[k].exp_acc});
      chk($sformatf("vec%0d_wrap", k), {63'd0, bus.wrap}, {63'd0, vecs[k].exp_wrap});
      chk($sformatf("vec%0d_conflict", k), {63'd0, bus.conflict}, {63'd0, vecs[k].exp_conf});
    end

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      bus.sel      = 2'($urandom_range(0, 3));
      bus.write_en = ($urandom_range(0, 3) == 0);
      bus.alu_en   = ($urandom_range(0, 3) == 0);
      bus.inc_en   = ($urandom_range(0, 1) == 1);
      bus.dataIn   = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      bus.aluIn    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                 : 16'($urandom);
      bus.step     = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4));
      bus.lim_we   = ($urandom_range(0, 7) == 0);
      bus.lim_sel  = 2'($urandom_range(0, 3));
      bus.rd_sel   = 2'($urandom_range(0, 3));
      tick("rand");
    end

    // Reset in the middle of a wrapping increment.
    drive_idle();
    bus.lim_we = 1'b1; bus.lim_sel = 2'd0; bus.dataIn = 16'd0;
    tick("prerst_lim");
    bus.lim_we = 1'b0; bus.sel = 2'd0; bus.alu_en = 1'b1; bus.aluIn = 16'hFFFF;
    bus.inc_en = 1'b1; bus.step = 16'd1;
    @(posedge clk);
    model_update();
    #2;
    chk("prerst_wrap", {63'd0, bus.wrap}, 64'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_flat",     bus.acc_flat, 64'd0);
    chk("midrst_zero",     {60'd0, bus.zero}, 64'hF);
    chk("midrst_wrap",     {63'd0, bus.wrap}, 64'd0);
    chk("midrst_conflict", {63'd0, bus.conflict}, 64'd0);
    @(negedge clk);
    model_check("rst_hold");
    drive_idle();
    rst = 1'b1;
    // Limits must also be cleared: a carry on channel 2 behaves as lim == 0.
    bus.sel = 2'd2; bus.alu_en = 1'b1; bus.aluIn = 16'hFFFE; bus.inc_en = 1'b1;
    bus.step = 16'd3; bus.rd_sel = 2'd2;
    tick("postrst");
    chk("postrst_acc2", {48'd0, bus.dataOut}, SAT ? 64'hFFFF : 64'h0001);
    drive_idle();
    tick("final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_bank.md
Name: acc_bank

Overview:
- Bank of NUM_ACC independent accumulator/counter registers, each WIDTH bits wide.
- Each register loads from the data bus or the ALU result and supports increment by a programmable stride.
- Each register has a per-channel wrap limit, and a wrap event is flagged whenever the limit is reached.
- Used as the loop-index and address counter file for the N-core matrix-multiply controller, which needs several row/column/k indices at once.

Parameters:
- WIDTH, 16, bit width of each accumulator, limit and stride.
- NUM_ACC, 4, number of accumulator channels (≥2).
- SEL_W, $clog2(NUM_ACC), width of the channel-select fields.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- sel  in  SEL_W  channel targeted by write_en/alu_en/inc_en
- dataIn  in  WIDTH  load value from data bus
- aluIn  in  WIDTH  load value from ALU
- write_en  in  1  load dataIn into acc[sel]
- alu_en  in  1  load aluIn into acc[sel]
- inc_en  in  1  add step to acc[sel] (after load if a load is also active)
- step  in  WIDTH  increment stride, unsigned
- lim_we  in  1  write dataIn into lim[lim_sel]
- lim_sel  in  SEL_W  channel whose limit is written
- rd_sel  in  SEL_W  channel driven on dataOut
- dataOut  out  WIDTH  acc[rd_sel], combinational mux of registers only
- acc_flat  out  NUM_ACC*WIDTH  all accumulators; channel i at bits [i*WIDTH +: WIDTH]
- wrap  out  1  registered 1-cycle pulse: the last increment wrapped
- conflict  out  1  registered 1-cycle pulse: write_en and alu_en were both high
- zero  out  NUM_ACC  bit i high when acc[i]==0, combinational from registers

Behaviour:
- Reset (rst low, async):
  - All acc[i] = 0 and all lim[i] = 0.
  - wrap = 0 and conflict = 0.
  - Consequently dataOut = 0 and zero = all ones.
- One operation per cycle, on acc[sel] only; all other channels hold.
- Base value b:
  - write_en & ~alu_en: b = dataIn.
  - alu_en & ~write_en: b = aluIn.
  - Neither load active: b = acc[sel].
- write_en & alu_en (any inc_en): acc[sel] holds, increment is suppressed, conflict = 1 next cycle.
- No inc_en: acc[sel] <= b at the edge (1-cycle latency to dataOut).
- inc_en: sum s = b + step, computed at WIDTH+1 bits.
  - lim[sel] == 0: acc <= s[WIDTH-1:0]; wrap = s[WIDTH].
  - lim[sel] != 0 and s >= lim[sel]: acc <= 0; wrap = 1.
  - lim[sel] != 0 and s < lim[sel]: acc <= s; wrap = 0.
- wrap and conflict are 0 in any cycle without the triggering condition; they are pulses and never stick.
- Limit writes:
  - lim_we updates lim[lim_sel] at the edge.
  - A limit written in the same cycle as an increment on that channel does not affect that increment; the old limit is used.
  - lim_we with write_en in the same cycle: both use dataIn, which is legal.
- Loading a value ≥ the limit without inc_en is allowed and stored unchanged; the limit is checked only on increment.
- step = 0 with inc_en behaves as a plain load/hold, except the limit check still applies (b ≥ lim → 0, wrap).
- rst asserted mid-operation overrides everything immediately; no partial update survives.

Optional Feature:
- Macro: ACC_BANK_SAT_EN.
- When defined, limit overflow saturates instead of wrapping:
  - lim != 0 and s ≥ lim: acc <= lim - 1.
  - lim == 0 and carry out: acc <= all ones.
  - wrap pulses in both cases and then means "saturated".
- When undefined, wrap-to-zero behaviour as above; no saturation logic is generated.

Decomposition:
- Package acc_bank_pkg:
  - Source-select enum {SRC_HOLD, SRC_DATA, SRC_ALU}.
  - Default WIDTH/NUM_ACC localparams.
  - Function for the WIDTH+1 limit-compare/next-value calculation, shared with the sub-module.
- Sub-module acc_cell, instantiated NUM_ACC times:
  - Holds one accumulator and its limit register.
  - Takes a one-hot channel enable plus the decoded source.
  - Outputs its value and a wrap request.
- Top level handles select decode, conflict detection, dataOut/zero muxing and registering of wrap/conflict.

Test Plan:
- Reset, then read every channel → dataOut = 0, zero = 4'b1111, wrap = conflict = 0. Assert rst low mid-increment → all clear immediately.
- sel=1, write_en, dataIn=0x0010, then 3 cycles inc_en with step=2 → acc[1] = 0x0010, 0x0012, 0x0014, 0x0016; other channels stay 0.
- lim[2]=5; sel=2, inc_en with step=1 from 0, five cycles → acc[2] sequence 1,2,3,4,0 with a wrap pulse on the fifth edge. With ACC_BANK_SAT_EN the sequence is 1,2,3,4,4,4 with a wrap pulse on each edge from the fifth onward.
- sel=0, alu_en with aluIn=0xFFFF and inc_en, step=1, lim=0 → acc[0] = 0x0000 and wrap pulses. With ACC_BANK_SAT_EN → 0xFFFF and wrap pulses.
- write_en & alu_en & inc_en together on sel=3 holding 0x0007 → acc[3] stays 0x0007, conflict pulses exactly one cycle.
- lim_we lim_sel=1 dataIn=3 in the same cycle as inc_en on sel=1 (acc=2, step=1, old lim=0) → acc[1] = 3 with no wrap. The next increment (step=1) → 0 with a wrap pulse.
